// File: rtl/alu_if_pkg.sv
// Shared definitions for the TP2 ALU byte-serial front end: FSM state encoding and ALU opcodes.
// SEND_FLG/WAIT_FLG are only reachable when ALU_IF_FLAGS_EN is defined.
package alu_if_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_A   = 3'd0,
        ST_WAIT_B   = 3'd1,
        ST_WAIT_OP  = 3'd2,
        ST_EXEC     = 3'd3,
        ST_SEND_RES = 3'd4,
        ST_WAIT_RES = 3'd5,
        ST_SEND_FLG = 3'd6,
        ST_WAIT_FLG = 3'd7
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

endpackage

// File: rtl/alu_uart_if.sv
// Collects A, B, opcode bytes for the ALU and transmits the result (plus a flag byte when ALU_IF_FLAGS_EN).
// Opcode rx_done to tx_start is 2 cycles; each byte waits on tx_done indefinitely, rx bytes during a frame's execute/transmit are dropped.
module alu_uart_if
    import alu_if_pkg::*;
#(
    parameter int N    = 8,
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      rx_data,
    input  logic            rx_done,
    input  logic            tx_done,
    output logic            tx_start,
    output logic [7:0]      tx_data,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [N-1:0]    alu_result,
    input  logic            alu_zero,
    input  logic            alu_carry,
    output logic            busy
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_alu_a;
    logic [N-1:0]    r_alu_b;
    logic [OP_W-1:0] r_alu_op;
    logic [7:0]      r_tx_data;
    logic [7:0]      w_res_ext;
    logic            w_ld_a;
    logic            w_ld_b;
    logic            w_ld_op;
    logic            w_ld_res;
    logic            w_tx_start;
    logic            w_unused;
`ifdef ALU_IF_FLAGS_EN
    logic [1:0]      r_flg_reg;
    logic            w_ld_flg;
`endif

    // Sink for input bits this configuration does not consume.
    assign w_unused = ^{rx_data, alu_zero, alu_carry};

    always_comb begin
        w_res_ext            = '0;
        w_res_ext[N-1:0]     = alu_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_a      = 1'b0;
        w_ld_b      = 1'b0;
        w_ld_op     = 1'b0;
        w_ld_res    = 1'b0;
        w_tx_start  = 1'b0;
`ifdef ALU_IF_FLAGS_EN
        w_ld_flg    = 1'b0;
`endif
        case (r_state)
            ST_WAIT_A: begin
                if (rx_done) begin
                    w_ld_a      = 1'b1;
                    w_state_nxt = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (rx_done) begin
                    w_ld_b      = 1'b1;
                    w_state_nxt = ST_WAIT_OP;
                end
            end
            ST_WAIT_OP: begin
                if (rx_done) begin
                    w_ld_op     = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_ld_res    = 1'b1;
                w_state_nxt = ST_SEND_RES;
            end
            ST_SEND_RES: begin
                w_tx_start  = 1'b1;
                w_state_nxt = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (tx_done) begin
`ifdef ALU_IF_FLAGS_EN
                    w_ld_flg    = 1'b1;
                    w_state_nxt = ST_SEND_FLG;
`else
                    w_state_nxt = ST_WAIT_A;
`endif
                end
            end
`ifdef ALU_IF_FLAGS_EN
            ST_SEND_FLG: begin
                w_tx_start  = 1'b1;
                w_state_nxt = ST_WAIT_FLG;
            end
            ST_WAIT_FLG: begin
                if (tx_done) begin
                    w_state_nxt = ST_WAIT_A;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_WAIT_A;
            end
        endcase
    end

    // The transmit register doubles as the result register: it is loaded only on entry to a SEND state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_tx_data <= '0;
`ifdef ALU_IF_FLAGS_EN
            r_flg_reg <= '0;
`endif
        end else begin
            if (w_ld_a) begin
                r_alu_a <= rx_data[N-1:0];
            end
            if (w_ld_b) begin
                r_alu_b <= rx_data[N-1:0];
            end
            if (w_ld_op) begin
                r_alu_op <= rx_data[OP_W-1:0];
            end
            if (w_ld_res) begin
                r_tx_data <= w_res_ext;
            end
`ifdef ALU_IF_FLAGS_EN
            if (w_ld_res) begin
                r_flg_reg <= {alu_carry, alu_zero};
            end
            if (w_ld_flg) begin
                r_tx_data <= {6'b0, r_flg_reg};
            end
`endif
        end
    end

    assign tx_start = w_tx_start;
    assign tx_data  = r_tx_data;
    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign busy     = (r_state != ST_WAIT_A);

endmodule

// File: tb/tb_alu_uart_if.sv
// Randomised bench for alu_uart_if: the bench plays ALU, UART receiver and transmitter, and checks a frame-level model every cycle.
// Flag-byte expectations are enabled when ALU_IF_FLAGS_EN is defined.
module tb_alu_uart_if;

`ifdef ALU_IF_FLAGS_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int tx_delay = 2;
    int last_rx_cyc = 0;

    logic [7:0] sent_q[$];
    int         sent_cyc_q[$];

    // frame-level reference model
    int         m_cnt = 0;
    logic [7:0] m_frm[3];
    logic [7:0] m_pend[$];
    int         m_due = -1;
    bit         m_sending = 1'b0;
    logic [7:0] m_txd = 8'h00;
    logic [7:0] ea = 8'h00;
    logic [7:0] eb = 8'h00;
    logic [5:0] eop = 6'h00;

    alu_uart_if #(.N(8), .OP_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .tx_done    (tx_done),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // returns {carry, zero, result}
    function automatic logic [9:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        c = 1'b0;
        r = 8'h00;
        case (op)
            6'h20: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
            6'h22: begin r = a - b; c = (a < b); end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h02: r = a >> b;
            6'h03: r = 8'($signed(a) >>> b);
            default: r = 8'h00;
        endcase
        return {c, (r == 8'h00), r};
    endfunction

    logic [9:0] alu_v;
    always_comb alu_v = alu_ref(alu_a, alu_b, alu_op);
    assign alu_result = alu_v[7:0];
    assign alu_zero   = alu_v[8];
    assign alu_carry  = alu_v[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0;
            m_pend.delete();
            m_due = -1;
            m_sending = 1'b0;
            m_txd = 8'h00;
            ea = 8'h00;
            eb = 8'h00;
            eop = 6'h00;
        end else begin
            if (m_cnt < 3 && rx_done) begin
                m_frm[m_cnt] = rx_data;
                if (m_cnt == 0) ea = rx_data;
                if (m_cnt == 1) eb = rx_data;
                if (m_cnt == 2) eop = rx_data[5:0];
                m_cnt++;
                if (m_cnt == 3) begin
                    logic [9:0] v;
                    v = alu_ref(m_frm[0], m_frm[1], m_frm[2][5:0]);
                    m_pend.push_back(v[7:0]);
`ifdef ALU_IF_FLAGS_EN
                    m_pend.push_back({6'b0, v[9], v[8]});
`endif
                    m_due = cyc + 2;
                end
            end else if (m_sending && tx_done) begin
                m_sending = 1'b0;
                void'(m_pend.pop_front());
                if (m_pend.size() > 0) m_due = cyc + 1;
                else m_cnt = 0;
            end
            if (cyc == m_due) m_sending = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic exp_start;
        exp_start = (cyc == m_due) && (m_pend.size() > 0);
        if (exp_start) m_txd = m_pend[0];
        chk("tx_start", tx_start, exp_start);
        chk("tx_data", tx_data, m_txd);
        chk("busy", busy, (m_cnt != 0));
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_op", alu_op, eop);
    end

    // UART transmitter stand-in
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                sent_q.push_back(tx_data);
                sent_cyc_q.push_back(cyc);
                repeat (tx_delay) begin
                    @(posedge clk);
                    #1;
                end
                tx_done = 1'b1;
                @(posedge clk);
                #1;
                tx_done = 1'b0;
            end
        end
    end

    task automatic rx_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_done = 1'b1;
        rx_data = b;
        last_rx_cyc = cyc;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic wait_idle(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk({nm, "_idle_timeout"}, busy, 1'b0);
    endtask

    task automatic check_frame(input string nm, input int n0, input logic [7:0] er, input logic [7:0] ef);
        chk({nm, "_nbytes"}, sent_q.size() - n0, NB);
        if (sent_q.size() >= n0 + NB) begin
            chk({nm, "_res"}, sent_q[n0], er);
`ifdef ALU_IF_FLAGS_EN
            chk({nm, "_flg"}, sent_q[n0 + 1], ef);
`else
            if (ef === 8'hxx) chk({nm, "_flg_arg"}, ef, 8'h00);
`endif
        end
    endtask

    task automatic run_frame(input string nm, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] er, input logic [7:0] ef);
        int n0;
        int rc;
        n0 = sent_q.size();
        rx_byte(a);
        rx_byte(b);
        rx_byte(op);
        rc = last_rx_cyc;
        wait_idle(nm);
        check_frame(nm, n0, er, ef);
        if (sent_cyc_q.size() > n0) chk({nm, "_latency"}, sent_cyc_q[n0] - rc, 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ops[8];
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        int n0;
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};

        rst_n = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_tx_start", tx_start, 1'b0);
        chk("reset_tx_data", tx_data, 8'h00);
        chk("reset_alu_op", alu_op, 6'h00);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_frame("add", 8'h05, 8'h03, 8'h20, 8'h08, 8'h00);
        run_frame("sub", 8'h03, 8'h05, 8'h22, 8'hFE, 8'h02);
        run_frame("and", 8'hF0, 8'h0F, 8'h24, 8'h00, 8'h01);
        run_frame("sra", 8'h80, 8'h03, 8'h03, 8'hF0, 8'h00);
        run_frame("sra_hi", 8'h80, 8'h03, 8'hC3, 8'hF0, 8'h00);
        run_frame("unknown_op", 8'h12, 8'h34, 8'h3F, 8'h00, 8'h01);

        // slow transmitter with a stray byte while waiting for tx_done
        tx_delay = 100;
        n0 = sent_q.size();
        rx_byte(8'h05);
        rx_byte(8'h03);
        rx_byte(8'h20);
        for (int i = 0; i < 20 && sent_q.size() == n0; i++) @(negedge clk);
        repeat (10) @(posedge clk);
        rx_byte(8'hAA);
        wait_idle("slow");
        check_frame("slow", n0, 8'h08, 8'h00);
        tx_delay = 2;
        run_frame("after_drop", 8'h01, 8'h02, 8'h20, 8'h03, 8'h00);

        // partial frame discarded by reset
        rx_byte(8'h11);
        rx_byte(8'h22);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_alu_a", alu_a, 8'h00);
        chk("midrst_alu_b", alu_b, 8'h00);
        chk("midrst_tx_data", tx_data, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame("post_rst", 8'h01, 8'h01, 8'h20, 8'h02, 8'h00);

        // reset while tx_start is high
        rx_byte(8'h07);
        rx_byte(8'h01);
        rx_byte(8'h20);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_start) break;
        end
        chk("async_seen_start", tx_start, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_drop_start", tx_start, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame("post_async", 8'h09, 8'h06, 8'h26, 8'h0F, 8'h00);

        for (int f = 0; f < 40; f++) begin
            tx_delay = $urandom_range(1, 6);
            a = 8'($urandom);
            b = 8'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) op = 8'($urandom);
            else op = {2'($urandom), ops[$urandom_range(0, 7)][5:0]};
            rx_byte(a);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            rx_byte(b);
            rx_byte(op);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk);
                    #1;
                    if (m_cnt == 3) begin
                        rx_done = 1'b1;
                        rx_data = 8'($urandom);
                        @(posedge clk);
                        #1;
                        rx_done = 1'b0;
                    end
                end
            end
            wait_idle("rand");
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_uart_if.md
# alu_uart_if

Byte-serial front end for the TP2 ALU. It sits between the UART receiver/transmitter and the combinational ALU. It collects three received bytes (operand A, operand B, opcode) and drives them onto the ALU inputs. It then captures the ALU result and flags in a register and hands the result byte, plus an optional flag byte, to the UART transmitter with a start/done handshake.

## Interface
Parameters:
- N, 8: ALU data width. Legal range 1..8. Operands take the low N bits of the received byte. The result is zero-extended to 8 bits for transmission.
- OP_W, 6: opcode width. Taken from the low OP_W bits of the opcode byte.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from the UART receiver; valid only while rx_done=1.
- rx_done  in  1  one-cycle pulse marking a received byte.
- tx_done  in  1  one-cycle pulse from the transmitter when the current byte has been fully sent.
- tx_start  out  1  one-cycle request to transmit tx_data.
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_done.
- alu_a  out  N  registered operand A to the ALU.
- alu_b  out  N  registered operand B to the ALU.
- alu_op  out  OP_W  registered opcode to the ALU.
- alu_result  in  N  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_zero  in  1  ALU zero flag.
- alu_carry  in  1  ALU carry/borrow flag.
- busy  out  1  high in every state except WAIT_A.

## Operation
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG. The last two exist only with the macro.
- WAIT_A: on rx_done, alu_a <= rx_data[N-1:0], go to WAIT_B.
- WAIT_B: on rx_done, alu_b <= rx_data[N-1:0], go to WAIT_OP.
- WAIT_OP: on rx_done, alu_op <= rx_data[OP_W-1:0], go to EXEC.
- EXEC: one cycle for the ALU to settle.
  - At its closing edge: res_reg <= zero-extended alu_result; flg_reg <= {alu_carry, alu_zero}.
  - Go to SEND_RES.
- SEND_RES: tx_start=1, tx_data=res_reg, go to WAIT_RES.
- WAIT_RES: hold until tx_done.
  - Without the macro, go to WAIT_A.
  - With the macro, go to SEND_FLG.
- rx_done pulses in EXEC, SEND_*, or WAIT_* transmit states are dropped. They do not queue and do not alter any register.
- Opcodes are not validated. An unknown opcode yields whatever the ALU returns (0), and it is transmitted normally.
- alu_a, alu_b and alu_op hold their values after the frame until overwritten by the next frame.
- A tx_done pulse outside WAIT_RES/WAIT_FLG is ignored.

## Timing
- Reset values:
  - state=WAIT_A; busy=0.
  - alu_a, alu_b, alu_op, res_reg, flg_reg = 0.
  - tx_start=0; tx_data=0x00.
- Reset asserted mid-frame or mid-transmission discards the partial frame immediately. tx_start drops asynchronously.
- Opcode byte accepted at edge k → EXEC during cycle k+1 → result captured at edge k+1 → tx_start high during cycle k+2 only.
- Latency is 2 cycles from opcode rx_done to tx_start.
- tx_start is high exactly one cycle per byte. tx_data is registered, changes only at the edge entering SEND_*, and is stable through the matching tx_done.
- rx_done and tx_done in the same cycle: only the one relevant to the current state acts.
- No timeout: WAIT_* states wait indefinitely.

## Configuration
- ALU_IF_FLAGS_EN defined:
  - After the result byte completes, SEND_FLG sends {6'b0, carry, zero}.
  - WAIT_FLG then waits for tx_done and returns to WAIT_A.
  - Two bytes are sent per frame.
- ALU_IF_FLAGS_EN undefined: SEND_FLG, WAIT_FLG and flg_reg are absent. One byte is sent per frame.

## Structure
- Shared package alu_if_pkg holds:
  - the state encoding (localparams or typedef);
  - opcode constants shared with the ALU: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRL 6'b000010, SRA 6'b000011.
- No sub-module: a single FSM plus datapath registers. The ALU is instantiated beside this block at the top level, not inside it.

## Test plan
- Frame 0x05, 0x03, 0x20 (ADD) → tx_start at 2 cycles after the 3rd rx_done, tx_data=0x08. With the macro, the second byte is 0x00.
- Frame 0x03, 0x05, 0x22 (SUB) → tx_data=0xFE. With the macro, the flag byte is 0x02 (carry=1, zero=0).
- Frame 0xF0, 0x0F, 0x24 (AND) → tx_data=0x00. With the macro, the flag byte is 0x01.
- Delay tx_done by 100 cycles and inject rx_done=1, rx_data=0xAA during WAIT_RES:
  - tx_data holds 0x08 and tx_start does not repeat;
  - 0xAA is dropped;
  - the next frame decodes correctly.
- Send A=0x11 and B=0x22, pulse rst_n low, then send frame 0x01, 0x01, 0x20 → tx_data=0x02. All outputs read reset values during reset.
- Frame 0x80, 0x03, 0x03 (SRA) → tx_data=0xF0. Opcode byte 0xC3 decodes to the same op (low 6 bits) → tx_data=0xF0.
